// File: rtl/des_round_ctrl.sv
`timescale 1ns/1ps
// des_round_ctrl
// Control sequencer for an iterative DES datapath that computes one round per
// cycle. It accepts a block, pulses load for one cycle, then issues 16 round
// enables with the key-rotate command for each round. The result is then held
// on a valid/ready output. A new block can be accepted in the same cycle that
// the previous result is taken.
module des_round_ctrl #(
  parameter int NUM_ROUNDS = 16,
  parameter int ROUND_W    = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic               decrypt_i,
  input  logic               abort_i,
  output logic               load_o,
  output logic               round_en_o,
  output logic [ROUND_W-1:0] round_o,
  output logic [1:0]         key_shift_o,
  output logic               key_dir_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

  state_t             state_q, state_d;
  logic [ROUND_W-1:0] cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic               accept;

  // The controller can take a request while idle, or while the finished
  // result is leaving in the same cycle. A request that arrives together with
  // an abort is dropped.
  assign in_ready_o = (state_q == IDLE) | ((state_q == DONE) & out_ready_i);
  assign accept     = in_valid_i & in_ready_o & ~abort_i;

  // State, round counter and latched direction registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state logic. Abort overrides every transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          mode_d  = decrypt_i;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = ROUND;
      end
      ROUND: begin
        if (cnt_q == LAST_ROUND) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + ROUND_W'(1);
        end
      end
      DONE: begin
        if (out_ready_i) begin
          if (accept) begin
            mode_d  = decrypt_i;
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // Per-round C/D rotate command. Decryption rotates right, with no shift
  // before the first round, so the key walks back through the encryption
  // schedule.
  always_comb begin
    key_shift_o = 2'd0;
    key_dir_o   = 1'b0;
    if (state_q == ROUND) begin
      key_dir_o = mode_q;
      if (mode_q && (cnt_q == ROUND_W'(0))) begin
        key_shift_o = 2'd0;
      end else if ((cnt_q == ROUND_W'(0)) || (cnt_q == ROUND_W'(1)) ||
                   (cnt_q == ROUND_W'(8)) || (cnt_q == ROUND_W'(15))) begin
        key_shift_o = 2'd1;
      end else begin
        key_shift_o = 2'd2;
      end
    end
  end

  assign load_o      = (state_q == LOAD);
  assign round_en_o  = (state_q == ROUND);
  assign round_o     = cnt_q;
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);

endmodule
